// File: rtl/fetch_unit.sv
// Instruction-fetch stage: addresses IMEM from the current PC, produces the
// next PC and its load strobe, and owns the IF/ID pipeline register together
// with the stall, redirect, halt and single-step control.
module fetch_unit #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              STALL,
    input  logic              REDIRECT,
    input  logic [31:0]       REDIRECT_PC,
    input  logic [31:0]       PC_CUR,
    input  logic [31:0]       IMEM_DATA,
    input  logic              SINGLE_STEP,
    input  logic              STEP,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [31:0]       PC_NEXT,
    output logic              PC_LOAD,
    output logic [31:0]       IFID_INSTR,
    output logic [31:0]       IFID_PC4,
    output logic              IFID_VALID,
    output logic              HALTED,
    output logic [31:0]       FETCH_COUNT
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_STEP,
        ST_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_plus4;
    logic        pc_load;

    // Redirect targets are word aligned, so the low byte-offset bits are dropped.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^REDIRECT_PC[1:0];

    // Next-state, IF/ID update and PC load strobe, evaluated in priority order.
    always_comb begin
        pc_plus4      = PC_CUR + 32'd4;
        PC_NEXT       = REDIRECT ? {REDIRECT_PC[31:2], 2'b00} : pc_plus4;
        state_d       = state_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;
        pc_load       = 1'b0;

        if (!ENABLE) begin
            // frozen: everything holds
        end else if (REDIRECT) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
            pc_load      = 1'b1;
            if (state_q == ST_HALT) state_d = ST_RUN;
        end else if (STALL) begin
            // IF/ID and PC hold
        end else if (state_q == ST_HALT) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
        end else if (state_q == ST_WAIT_STEP && !SINGLE_STEP) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
            state_d      = ST_RUN;
        end else if (state_q == ST_WAIT_STEP && !STEP) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
        end else if (IMEM_DATA == HALT_WORD) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
            state_d      = ST_HALT;
        end else begin
            ifid_instr_d  = IMEM_DATA;
            ifid_pc4_d    = pc_plus4;
            ifid_valid_d  = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
            pc_load       = 1'b1;
            state_d       = SINGLE_STEP ? ST_WAIT_STEP : ST_RUN;
        end
    end

    // State and IF/ID register, asynchronously cleared by RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_RUN;
            ifid_instr_q  <= '0;
            ifid_pc4_q    <= '0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign IMEM_ADDR   = PC_CUR[ADDR_W+1:2];
    assign PC_LOAD     = pc_load;
    assign IFID_INSTR  = ifid_instr_q;
    assign IFID_PC4    = ifid_pc4_q;
    assign IFID_VALID  = ifid_valid_q;
    assign HALTED      = (state_q == ST_HALT);
    assign FETCH_COUNT = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the MIPS pipeline. It sits directly downstream of the program counter register. It reads the current PC, addresses instruction memory, and computes the next PC and its load strobe. These are fed back to the PC's data-in and control inputs. It also owns the IF/ID pipeline register and applies stall, branch/jump redirect, halt detection and single-step debug control.

Parameters:
ADDR_W, 10, instruction-memory word-address width.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
ENABLE  in  1  global run enable from debug unit; 0 freezes the block
STALL  in  1  load-use/hazard stall request from ID
REDIRECT  in  1  taken branch/jump resolved in EX
REDIRECT_PC  in  32  redirect target byte address
PC_CUR  in  32  current PC from program counter
IMEM_DATA  in  32  instruction word, combinational read of IMEM_ADDR
SINGLE_STEP  in  1  debug single-step mode
STEP  in  1  one-cycle pulse: release one fetch in step mode
IMEM_ADDR  out  ADDR_W  word address = PC_CUR[ADDR_W+1:2]
PC_NEXT  out  32  next PC to program counter data-in
PC_LOAD  out  1  load strobe to program counter control input
IFID_INSTR  out  32  latched instruction
IFID_PC4  out  32  latched PC_CUR+4
IFID_VALID  out  1  IF/ID holds a real instruction
HALTED  out  1  state == HALT
FETCH_COUNT  out  32  count of instructions delivered to IF/ID

Behaviour:
- Reset values: IFID_INSTR=0 (NOP), IFID_PC4=0, IFID_VALID=0, FETCH_COUNT=0, state=RUN, HALTED=0. Reset asserted mid-operation aborts everything immediately.
- PC_NEXT is combinational: REDIRECT ? {REDIRECT_PC[31:2],2'b00} : PC_CUR+4, mod 2^32. 32'hFFFF_FFFC+4 wraps to 0.
- PC_LOAD and IMEM_ADDR are combinational. The program counter samples PC_LOAD on the same edge the IF/ID register updates, giving zero extra latency.
- FSM states: RUN, WAIT_STEP, HALT. A "fetch" means: IFID_INSTR<=IMEM_DATA, IFID_PC4<=PC_CUR+4, IFID_VALID<=1, FETCH_COUNT+=1, PC_LOAD=1.
- A "bubble" means: IFID_VALID<=0, IFID_INSTR<=0, PC_LOAD=0.
- Priority per cycle, first match wins:
  1. ENABLE=0: all registers hold, PC_LOAD=0, REDIRECT ignored.
  2. REDIRECT=1: flush. IFID_VALID<=0, IFID_INSTR<=0, PC_LOAD=1 with PC_NEXT=target. This applies even with STALL=1. HALT->RUN; RUN and WAIT_STEP unchanged.
  3. STALL=1: IF/ID holds, PC_LOAD=0, state unchanged.
  4. HALT: bubble, stay in HALT. Exit only via REDIRECT or RESET.
  5. WAIT_STEP with SINGLE_STEP=0: bubble, ->RUN.
  6. WAIT_STEP with STEP=0: bubble, stay in WAIT_STEP.
  7. RUN, or WAIT_STEP with STEP=1:
     - If IMEM_DATA==HALT_WORD: bubble, ->HALT. The halt word is never latched and not counted.
     - Otherwise: fetch, then ->WAIT_STEP if SINGLE_STEP=1, else ->RUN.
- STEP outside WAIT_STEP is ignored and is not remembered.
- A speculative halt word behind a taken branch is cancelled by the following REDIRECT, which returns the FSM to RUN.
- FETCH_COUNT wraps at 2^32 with no saturation.

Test Plan:
- Reset, ENABLE=1, PC_CUR steps 0,4,8 with IMEM_DATA=A,B,C -> PC_NEXT=4,8,12, PC_LOAD=1 each cycle; IFID_INSTR=A,B,C one cycle later; IFID_PC4=4,8,12; FETCH_COUNT=3.
- STALL=1 for 2 cycles at PC_CUR=8 -> PC_LOAD=0; IFID holds B/8/valid; FETCH_COUNT unchanged; fetch resumes on the third cycle.
- REDIRECT=1, REDIRECT_PC=0x103 with STALL=1 -> PC_NEXT=0x100, PC_LOAD=1, IFID_VALID=0, IFID_INSTR=0 next edge.
- IMEM_DATA=HALT_WORD at PC_CUR=0x20 -> HALTED=1, PC_LOAD=0 thereafter, IFID_VALID=0, count unchanged. Then REDIRECT to 0x40 -> HALTED=0, fetch resumes from 0x40.
- SINGLE_STEP=1 -> exactly one fetch, then WAIT_STEP with bubbles. A STEP pulse gives exactly one more fetch. Dropping SINGLE_STEP -> RUN on the next edge.
- ENABLE=0 with REDIRECT=1 -> all outputs hold, PC_LOAD=0. RESET pulse mid-stream -> IFID_VALID=0 and FETCH_COUNT=0 immediately, asynchronously.
